inst_axi_bridge: RTL and testbench

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge_if.sv | 52 +++++
 rtl/inst_axi_bridge.sv | 114 +++++++++++
 tb/tb_inst_axi_bridge.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_if.sv
// Signal bundle between the fetch-side SRAM-like port, the bridge and the AXI read channels.
// The master modport is the bridge view; the slave modport is the fetch stage plus AXI slave view.
interface inst_axi_bridge_if;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        bus_err;

   modport master (
      input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready, bus_err
   );

   modport slave (
      output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
             inst_sram_addr, inst_sram_wdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready, bus_err
   );
endinterface

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the instruction-fetch SRAM-like port to single-beat AXI reads.
// One AR in flight at a time, up to MAX_OUTST reads awaiting R, responses returned in order.
//
// state   | meaning
// AR_IDLE | no AR pending; a new fetch may be accepted
// AR_WAIT | AR latched and driven, waiting for arready
module inst_axi_bridge #(
   parameter int MAX_OUTST = 2
) (
   input logic               clk,
   input logic               reset,
   inst_axi_bridge_if.master bus
);

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_WAIT = 1'b1
   } ar_state_t;

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTST);

   ar_state_t   state;
   ar_state_t   state_nxt;
   logic [1:0]  outst_cnt;
   logic [31:0] araddr_q;
   logic [1:0]  arsize_q;
   logic        rready_q;
   logic        data_ok_q;
   logic        bus_err_q;
   logic [31:0] rdata_q;

   logic addr_ok;
   logic ar_hs;
   logic r_hs;
   logic r_retire;
   logic unused_inputs;

   // addr_ok is gated by reset so nothing is accepted while the block is held in reset
   assign addr_ok  = !reset && bus.inst_sram_req && (state == AR_IDLE) && (outst_cnt < MAX_CNT);
   assign ar_hs    = (state == AR_WAIT) && bus.arready;
   assign r_hs     = bus.rvalid && rready_q;
   assign r_retire = r_hs && bus.rlast && (outst_cnt != 2'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         AR_IDLE: if (addr_ok) state_nxt = AR_WAIT;
         AR_WAIT: if (ar_hs)   state_nxt = AR_IDLE;
         default:              state_nxt = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= AR_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outst_cnt <= 2'd0;
      end else begin
         case ({addr_ok, r_retire})
            2'b10:   outst_cnt <= outst_cnt + 2'd1;
            2'b01:   outst_cnt <= outst_cnt - 2'd1;
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         araddr_q <= 32'h0;
         arsize_q <= 2'd0;
      end else if (addr_ok) begin
         araddr_q <= bus.inst_sram_addr;
         arsize_q <= bus.inst_sram_size;
      end
   end

   // R channel never backpressures; every beat is forwarded the following cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         bus_err_q <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         rready_q  <= 1'b1;
         data_ok_q <= r_hs;
         bus_err_q <= r_hs && (bus.rresp != 2'b00);
         if (r_hs) rdata_q <= bus.rdata;
      end
   end

   assign bus.inst_sram_addr_ok = addr_ok;
   assign bus.inst_sram_data_ok = data_ok_q;
   assign bus.inst_sram_rdata   = rdata_q;
   assign bus.bus_err           = bus_err_q;
   assign bus.rready            = rready_q;

   assign bus.arid    = 4'h0;
   assign bus.araddr  = araddr_q;
   assign bus.arlen   = 8'h0;
   assign bus.arsize  = {1'b0, arsize_q};
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'h0;
   assign bus.arprot  = 3'h0;
   assign bus.arvalid = (state == AR_WAIT);

   // write-side fields and rid carry no meaning for a read-only, single-ID bridge
   assign unused_inputs = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: directed scenarios plus a randomized run against a queue-based model.
module tb_inst_axi_bridge;

   localparam int MAX = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   inst_axi_bridge_if bif();

   inst_axi_bridge #(.MAX_OUTST(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bif.inst_sram_req   = 1'b0;
      bif.inst_sram_wr    = 1'b0;
      bif.inst_sram_size  = 2'd2;
      bif.inst_sram_wstrb = 4'h0;
      bif.inst_sram_addr  = 32'h0;
      bif.inst_sram_wdata = 32'h0;
      bif.arready         = 1'b0;
      bif.rid             = 4'h0;
      bif.rdata           = 32'h0;
      bif.rresp           = 2'b00;
      bif.rlast           = 1'b0;
      bif.rvalid          = 1'b0;
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      bif.inst_sram_req = 1'b1;
      #1;
      checks++;
      if ({bif.inst_sram_addr_ok, bif.arvalid, bif.rready, bif.inst_sram_data_ok, bif.bus_err} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {bif.inst_sram_addr_ok, bif.arvalid, bif.rready, bif.inst_sram_data_ok, bif.bus_err});
      end
      checks++;
      if (bif.araddr !== 32'h0 || bif.inst_sram_rdata !== 32'h0 || dut.outst_cnt !== 2'd0) begin
         errors++; $display("FAIL reset_regs araddr %h rdata %h cnt %0d exp all 0", bif.araddr, bif.inst_sram_rdata, dut.outst_cnt);
      end
      checks++;
      if ({bif.arid, bif.arlen, bif.arburst, bif.arlock, bif.arcache, bif.arprot} !== {4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'h0}) begin
         errors++; $display("FAIL ar_constants got %h", {bif.arid, bif.arlen, bif.arburst, bif.arlock, bif.arcache, bif.arprot});
      end
      tick();
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b0 || bif.rready !== 1'b0) begin
         errors++; $display("FAIL reset_held addr_ok %b rready %b exp 0 0", bif.inst_sram_addr_ok, bif.rready);
      end
      bif.inst_sram_req = 1'b0;
      reset = 1'b0;
      tick();
      checks++;
      if (bif.rready !== 1'b1) begin
         errors++; $display("FAIL rready_after_reset got %b exp 1", bif.rready);
      end
   endtask

   task automatic test_single_fetch();
      bif.inst_sram_req  = 1'b1;
      bif.inst_sram_addr = 32'h1c00_0000;
      bif.inst_sram_size = 2'd2;
      bif.arready        = 1'b1;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1) begin
         errors++; $display("FAIL single_addr_ok got %b exp 1", bif.inst_sram_addr_ok);
      end
      tick();
      bif.inst_sram_req = 1'b0;
      #1;
      checks++;
      if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1c00_0000 || bif.arsize !== 3'b010) begin
         errors++; $display("FAIL single_ar arvalid %b araddr %h arsize %b exp 1 1c000000 010", bif.arvalid, bif.araddr, bif.arsize);
      end
      tick();
      bif.rvalid = 1'b1; bif.rdata = 32'h0280_0c0c; bif.rresp = 2'b00; bif.rlast = 1'b1;
      #1;
      checks++;
      if (bif.arvalid !== 1'b0 || bif.inst_sram_data_ok !== 1'b0) begin
         errors++; $display("FAIL single_t2 arvalid %b data_ok %b exp 0 0", bif.arvalid, bif.inst_sram_data_ok);
      end
      tick();
      bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h0280_0c0c || bif.bus_err !== 1'b0) begin
         errors++; $display("FAIL single_data data_ok %b rdata %h bus_err %b exp 1 02800c0c 0", bif.inst_sram_data_ok, bif.inst_sram_rdata, bif.bus_err);
      end
      tick();
      checks++;
      if (bif.inst_sram_data_ok !== 1'b0 || bif.inst_sram_rdata !== 32'h0280_0c0c) begin
         errors++; $display("FAIL single_hold data_ok %b rdata %h exp 0 02800c0c", bif.inst_sram_data_ok, bif.inst_sram_rdata);
      end
   endtask

   task automatic test_ar_backpressure();
      int bad_ar;
      int bad_ok;
      bad_ar = 0;
      bad_ok = 0;
      bif.arready        = 1'b0;
      bif.inst_sram_req  = 1'b1;
      bif.inst_sram_addr = 32'h1c00_0040;
      bif.inst_sram_size = 2'd2;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1) begin
         errors++; $display("FAIL bp_accept got %b exp 1", bif.inst_sram_addr_ok);
      end
      tick();
      for (int i = 0; i < 5; i++) begin
         bif.inst_sram_addr = 32'h2000_0000 + 32'(i * 4);
         bif.arready = (i == 4);
         #1;
         if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1c00_0040 || bif.arsize !== 3'b010) bad_ar++;
         if (bif.inst_sram_addr_ok !== 1'b0) bad_ok++;
         tick();
      end
      checks++;
      if (bad_ar != 0) begin
         errors++; $display("FAIL bp_ar_stable bad cycles %0d exp 0", bad_ar);
      end
      checks++;
      if (bad_ok != 0) begin
         errors++; $display("FAIL bp_addr_ok_blocked pulses %0d exp 0", bad_ok);
      end
      bif.inst_sram_req = 1'b0;
      bif.arready = 1'b0;
      bif.rvalid = 1'b1; bif.rdata = 32'h0bad_f00d; bif.rlast = 1'b1;
      #1;
      checks++;
      if (bif.arvalid !== 1'b0) begin
         errors++; $display("FAIL bp_handshake arvalid %b exp 0", bif.arvalid);
      end
      tick();
      bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h0bad_f00d) begin
         errors++; $display("FAIL bp_data data_ok %b rdata %h exp 1 0badf00d", bif.inst_sram_data_ok, bif.inst_sram_rdata);
      end
      tick();
   endtask

   task automatic test_outstanding_limit();
      int pulses;
      pulses = 0;
      bif.inst_sram_req = 1'b1;
      bif.arready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bif.inst_sram_addr = 32'h1c00_0100 + 32'(i * 4);
         #1;
         if (bif.inst_sram_addr_ok === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != MAX) begin
         errors++; $display("FAIL outst_pulses got %0d exp %0d", pulses, MAX);
      end
      bif.inst_sram_addr = 32'h1c00_0120;
      bif.rvalid = 1'b1; bif.rdata = 32'h1111_0001; bif.rlast = 1'b1;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b0) begin
         errors++; $display("FAIL outst_third_blocked got %b exp 0", bif.inst_sram_addr_ok);
      end
      tick();
      bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1) begin
         errors++; $display("FAIL outst_reopen got %b exp 1", bif.inst_sram_addr_ok);
      end
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h1111_0001) begin
         errors++; $display("FAIL outst_data0 data_ok %b rdata %h exp 1 11110001", bif.inst_sram_data_ok, bif.inst_sram_rdata);
      end
      tick();
      bif.inst_sram_req = 1'b0;
      #1;
      checks++;
      if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1c00_0120) begin
         errors++; $display("FAIL outst_new_ar arvalid %b araddr %h exp 1 1c000120", bif.arvalid, bif.araddr);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         bif.rvalid = 1'b1; bif.rlast = 1'b1; bif.rdata = 32'h1111_0002 + 32'(k);
         tick();
         bif.rvalid = 1'b0; bif.rlast = 1'b0;
         #1;
         checks++;
         if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h1111_0002 + 32'(k)) begin
            errors++; $display("FAIL outst_drain%0d data_ok %b rdata %h exp 1 %h", k, bif.inst_sram_data_ok, bif.inst_sram_rdata, 32'h1111_0002 + 32'(k));
         end
      end
      tick();
      checks++;
      if (dut.outst_cnt !== 2'd0) begin
         errors++; $display("FAIL outst_drained cnt %0d exp 0", dut.outst_cnt);
      end
   endtask

   task automatic test_simultaneous();
      bif.inst_sram_req = 1'b1; bif.inst_sram_addr = 32'h1c00_0000; bif.arready = 1'b1;
      #1;
      tick();
      bif.inst_sram_req = 1'b0;
      #1;
      tick();
      bif.inst_sram_req = 1'b1; bif.inst_sram_addr = 32'h1c00_0004;
      bif.rvalid = 1'b1; bif.rdata = 32'h1c00_0000; bif.rlast = 1'b1;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1 || dut.outst_cnt !== 2'd1) begin
         errors++; $display("FAIL simul_accept addr_ok %b cnt %0d exp 1 1", bif.inst_sram_addr_ok, dut.outst_cnt);
      end
      tick();
      bif.inst_sram_req = 1'b0; bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (dut.outst_cnt !== 2'd1) begin
         errors++; $display("FAIL simul_cnt_unchanged cnt %0d exp 1", dut.outst_cnt);
      end
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h1c00_0000 || bif.araddr !== 32'h1c00_0004) begin
         errors++; $display("FAIL simul_first data_ok %b rdata %h araddr %h exp 1 1c000000 1c000004", bif.inst_sram_data_ok, bif.inst_sram_rdata, bif.araddr);
      end
      tick();
      bif.rvalid = 1'b1; bif.rdata = 32'h1c00_0004; bif.rlast = 1'b1;
      tick();
      bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h1c00_0004 || dut.outst_cnt !== 2'd0) begin
         errors++; $display("FAIL simul_second data_ok %b rdata %h cnt %0d exp 1 1c000004 0", bif.inst_sram_data_ok, bif.inst_sram_rdata, dut.outst_cnt);
      end
      tick();
   endtask

   task automatic test_error_response();
      bif.inst_sram_req = 1'b1; bif.inst_sram_wr = 1'b1; bif.inst_sram_wstrb = 4'hf;
      bif.inst_sram_wdata = 32'hffff_ffff; bif.inst_sram_addr = 32'h1c00_0200;
      bif.inst_sram_size = 2'd1; bif.arready = 1'b1;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1) begin
         errors++; $display("FAIL wr_as_read_accept got %b exp 1", bif.inst_sram_addr_ok);
      end
      tick();
      bif.inst_sram_req = 1'b0; bif.inst_sram_wr = 1'b0; bif.inst_sram_size = 2'd2;
      #1;
      checks++;
      if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1c00_0200 || bif.arsize !== 3'b001) begin
         errors++; $display("FAIL wr_as_read_ar arvalid %b araddr %h arsize %b exp 1 1c000200 001", bif.arvalid, bif.araddr, bif.arsize);
      end
      tick();
      bif.rvalid = 1'b1; bif.rdata = 32'hdead_beef; bif.rresp = 2'b10; bif.rlast = 1'b1;
      #1;
      checks++;
      if (bif.bus_err !== 1'b0) begin
         errors++; $display("FAIL err_early bus_err %b exp 0", bif.bus_err);
      end
      tick();
      bif.rvalid = 1'b0; bif.rresp = 2'b00; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'hdead_beef || bif.bus_err !== 1'b1) begin
         errors++; $display("FAIL err_resp data_ok %b rdata %h bus_err %b exp 1 deadbeef 1", bif.inst_sram_data_ok, bif.inst_sram_rdata, bif.bus_err);
      end
      tick();
      checks++;
      if (bif.bus_err !== 1'b0 || bif.inst_sram_data_ok !== 1'b0) begin
         errors++; $display("FAIL err_pulse_width bus_err %b data_ok %b exp 0 0", bif.bus_err, bif.inst_sram_data_ok);
      end
   endtask

   task automatic test_reset_midflight();
      bif.inst_sram_req = 1'b1; bif.inst_sram_addr = 32'h1c00_0300; bif.arready = 1'b1;
      #1;
      tick();
      bif.inst_sram_req = 1'b0;
      #1;
      tick();
      bif.inst_sram_req = 1'b1; bif.inst_sram_addr = 32'h1c00_0304; bif.arready = 1'b0;
      #1;
      tick();
      bif.inst_sram_req = 1'b1;
      #1;
      checks++;
      if (bif.arvalid !== 1'b1 || dut.outst_cnt !== 2'd2) begin
         errors++; $display("FAIL midflight_setup arvalid %b cnt %0d exp 1 2", bif.arvalid, dut.outst_cnt);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bif.arvalid !== 1'b0 || bif.rready !== 1'b0 || bif.inst_sram_addr_ok !== 1'b0 || dut.outst_cnt !== 2'd0) begin
         errors++; $display("FAIL midflight_async arvalid %b rready %b addr_ok %b cnt %0d exp 0 0 0 0", bif.arvalid, bif.rready, bif.inst_sram_addr_ok, dut.outst_cnt);
      end
      tick();
      tick();
      idle();
      reset = 1'b0;
      bif.inst_sram_req = 1'b1; bif.inst_sram_addr = 32'h1c00_0400; bif.arready = 1'b1;
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b1 || bif.inst_sram_data_ok !== 1'b0) begin
         errors++; $display("FAIL midflight_release addr_ok %b data_ok %b exp 1 0", bif.inst_sram_addr_ok, bif.inst_sram_data_ok);
      end
      tick();
      bif.inst_sram_req = 1'b0;
      #1;
      checks++;
      if (bif.rready !== 1'b1 || bif.arvalid !== 1'b1 || bif.araddr !== 32'h1c00_0400 || bif.inst_sram_data_ok !== 1'b0) begin
         errors++; $display("FAIL midflight_new_ar rready %b arvalid %b araddr %h data_ok %b exp 1 1 1c000400 0", bif.rready, bif.arvalid, bif.araddr, bif.inst_sram_data_ok);
      end
      tick();
      bif.rvalid = 1'b1; bif.rdata = 32'hcafe_f00d; bif.rlast = 1'b1;
      tick();
      bif.rvalid = 1'b0; bif.rlast = 1'b0;
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'hcafe_f00d) begin
         errors++; $display("FAIL midflight_data data_ok %b rdata %h exp 1 cafef00d", bif.inst_sram_data_ok, bif.inst_sram_rdata);
      end
      tick();
   endtask

   // Model: a request is accepted when no AR is pending and fewer than MAX
   // fetches are unanswered; answers come back in acceptance order.
   task automatic test_random();
      logic [31:0] req_q[$];
      logic [31:0] slv_q[$];
      logic        m_pend;
      logic [31:0] m_pend_addr;
      logic [1:0]  m_pend_size;
      logic        m_dok;
      logic        m_err;
      logic [31:0] m_last;
      logic        exp_ok;
      logic        beat;
      logic        drain;
      logic [1:0]  rr;
      logic [31:0] a;
      logic [1:0]  s;
      logic        hs;
      int          accepted;
      m_pend = 1'b0; m_dok = 1'b0; m_err = 1'b0; m_last = 32'hcafe_f00d;
      m_pend_addr = 32'h0; m_pend_size = 2'd0; accepted = 0;
      for (int c = 0; c < 500; c++) begin
         drain = (c >= 440);
         a = $urandom() & 32'hffff_fffc;
         s = 2'($urandom_range(0, 2));
         bif.inst_sram_req   = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
         bif.inst_sram_addr  = a;
         bif.inst_sram_size  = s;
         bif.inst_sram_wr    = 1'($urandom_range(0, 1));
         bif.inst_sram_wstrb = 4'($urandom_range(0, 15));
         bif.inst_sram_wdata = $urandom();
         bif.arready         = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         beat = (slv_q.size() != 0) && (drain || $urandom_range(0, 2) != 0);
         rr = 2'b00;
         if (beat && $urandom_range(0, 5) == 0) rr = 2'b10;
         else if (beat && $urandom_range(0, 9) == 0) rr = 2'b11;
         bif.rvalid = beat;
         bif.rdata  = beat ? word_of(slv_q[0]) : $urandom();
         bif.rresp  = rr;
         bif.rlast  = beat ? 1'b1 : 1'b0;
         bif.rid    = 4'($urandom_range(0, 15));
         #1;
         exp_ok = bif.inst_sram_req && !m_pend && (req_q.size() < MAX);
         checks++;
         if (bif.inst_sram_addr_ok !== exp_ok) begin
            errors++; if (errors < 20) $display("FAIL rand_addr_ok cyc %0d got %b exp %b", c, bif.inst_sram_addr_ok, exp_ok);
         end
         checks++;
         if (bif.arvalid !== m_pend || (m_pend && (bif.araddr !== m_pend_addr || bif.arsize !== {1'b0, m_pend_size}))) begin
            errors++; if (errors < 20) $display("FAIL rand_ar cyc %0d arvalid %b araddr %h arsize %b exp %b %h %b", c, bif.arvalid, bif.araddr, bif.arsize, m_pend, m_pend_addr, {1'b0, m_pend_size});
         end
         checks++;
         if (bif.inst_sram_data_ok !== m_dok || bif.inst_sram_rdata !== m_last || bif.bus_err !== (m_dok && m_err) || bif.rready !== 1'b1) begin
            errors++; if (errors < 20) $display("FAIL rand_r cyc %0d data_ok %b rdata %h bus_err %b rready %b exp %b %h %b 1", c, bif.inst_sram_data_ok, bif.inst_sram_rdata, bif.bus_err, bif.rready, m_dok, m_last, m_dok && m_err);
         end
         hs = m_pend && bif.arready;
         if (hs) slv_q.push_back(bif.araddr);
         tick();
         m_dok = beat;
         if (beat) begin
            m_err = (rr != 2'b00);
            void'(slv_q.pop_front());
            if (req_q.size() != 0) m_last = word_of(req_q.pop_front());
         end
         if (hs) m_pend = 1'b0;
         if (exp_ok) begin
            m_pend = 1'b1; m_pend_addr = a; m_pend_size = s;
            req_q.push_back(a);
            accepted++;
         end
      end
      checks++;
      if (req_q.size() != 0 || m_pend || accepted < 50) begin
         errors++; $display("FAIL rand_drain left %0d pending %b accepted %0d exp 0 0 >=50", req_q.size(), m_pend, accepted);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_single_fetch();
      test_ar_backpressure();
      test_outstanding_limit();
      test_simultaneous();
      test_error_response();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached, checks %0d", checks);
      $fatal(1, "timeout");
   end

endmodule
